// File: rtl/gsm_ram_fifo_ctrl.sv
// FIFO controller over a dual-port registered-read RAM; optional almost_full via GSM_RAM_FIFO_ALMOST_FULL_EN.
// Latency: 2 cycles from accept to out_valid. Backpressure: in_ready drops when the RAM holds DEPTH words; reads stall while the 2-entry output buffer is committed.
module gsm_ram_fifo_ctrl #(
    parameter int DWIDTH = 18,
    parameter int AWIDTH = 10
`ifdef GSM_RAM_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL = 2**AWIDTH - 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH+1:0] count,
`ifdef GSM_RAM_FIFO_ALMOST_FULL_EN
    output logic              almost_full,
`endif
    output logic              ram_write_a,
    output logic [AWIDTH-1:0] ram_addr_a,
    output logic [DWIDTH-1:0] ram_din_a,
    output logic              ram_en_b,
    output logic              ram_write_b,
    output logic [AWIDTH-1:0] ram_addr_b,
    input  logic [DWIDTH-1:0] ram_dout_b
);

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic [1:0]        obuf_cnt_q, obuf_cnt_d;
    logic              obuf_head_q, obuf_head_d;
    logic [DWIDTH-1:0] obuf0_q, obuf0_d;
    logic [DWIDTH-1:0] obuf1_q, obuf1_d;
    logic              accept, pop, tail;
    logic [2:0]        committed;
    logic [AWIDTH+1:0] count_d;

    always_comb begin
        // ram_cnt can only reach DEPTH, so its MSB alone marks full
        in_ready    = ~ram_cnt_q[AWIDTH];
        accept      = in_valid & in_ready;
        out_valid   = (obuf_cnt_q != 2'd0);
        pop         = out_valid & out_ready;
        out_data    = obuf_head_q ? obuf1_q : obuf0_q;
        committed   = {1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
        ram_en_b    = (ram_cnt_q != '0) & (committed < 3'd2);
        ram_write_a = accept;
        ram_addr_a  = wr_ptr_q;
        ram_din_a   = in_data;
        ram_write_b = 1'b0;
        ram_addr_b  = rd_ptr_q;

        wr_ptr_d      = wr_ptr_q + {{(AWIDTH-1){1'b0}}, accept};
        rd_ptr_d      = rd_ptr_q + {{(AWIDTH-1){1'b0}}, ram_en_b};
        ram_cnt_d     = ram_cnt_q + {{AWIDTH{1'b0}}, accept} - {{AWIDTH{1'b0}}, ram_en_b};
        rd_inflight_d = ram_en_b;
        obuf_cnt_d    = obuf_cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop};
        obuf_head_d   = obuf_head_q ^ pop;

        // With two entries held and a pop, the tail slot equals the slot being vacated
        tail    = obuf_head_q ^ obuf_cnt_q[0];
        obuf0_d = obuf0_q;
        obuf1_d = obuf1_q;
        if (rd_inflight_q) begin
            if (tail) obuf1_d = ram_dout_b;
            else      obuf0_d = ram_dout_b;
        end

        count   = {1'b0, ram_cnt_q} + {{(AWIDTH+1){1'b0}}, rd_inflight_q}
                + {{AWIDTH{1'b0}}, obuf_cnt_q};
        count_d = {1'b0, ram_cnt_d} + {{(AWIDTH+1){1'b0}}, rd_inflight_d}
                + {{AWIDTH{1'b0}}, obuf_cnt_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            obuf_cnt_q    <= 2'd0;
            obuf_head_q   <= 1'b0;
            obuf0_q       <= '0;
            obuf1_q       <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf_cnt_q    <= obuf_cnt_d;
            obuf_head_q   <= obuf_head_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
        end
    end

`ifdef GSM_RAM_FIFO_ALMOST_FULL_EN
    localparam logic [AWIDTH+1:0] AF_C = AF_LEVEL[AWIDTH+1:0];
    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = (count_d >= AF_C);
        almost_full   = almost_full_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) almost_full_q <= 1'b0;
        else        almost_full_q <= almost_full_d;
    end
`else
    logic unused_count_d;
    assign unused_count_d = ^count_d;
`endif

endmodule

// File: doc/gsm_ram_fifo_ctrl.md
Name: gsm_ram_fifo_ctrl

Overview:
- FIFO controller for a dual-port write-through RAM used as a GSM switch cell/frame buffer.
- Drives RAM port A for writes and port B for reads; consumes the RAM's registered read data (dout_b).
- Presents valid/ready streams upstream and downstream, hides the 1-cycle RAM read latency, and sustains one word per clock.
- Sits between the ingress framer and the RAM; its read side feeds the egress scheduler.

Parameters:
- DWIDTH, 18, data width; must match the RAM.
- AWIDTH, 10, RAM address width; DEPTH = 2**AWIDTH words.
- AF_LEVEL, 2**AWIDTH-4, almost-full threshold on count; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DWIDTH  upstream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DWIDTH  head-of-FIFO word.
- count  out  AWIDTH+2  total words held (RAM + in-flight + output buffer).
- ram_write_a  out  1  port A write strobe.
- ram_addr_a  out  AWIDTH  write pointer.
- ram_din_a  out  DWIDTH  equals in_data.
- ram_en_b  out  1  port B read enable.
- ram_write_b  out  1  tied 0.
- ram_addr_b  out  AWIDTH  read pointer.
- ram_dout_b  in  DWIDTH  RAM read data; valid the cycle after the read is issued.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_inflight=0, obuf_cnt=0.
  - out_valid=0, out_data=0, count=0, in_ready=1, ram_write_a=0, ram_en_b=0.
  - Reset mid-operation discards all contents immediately. RAM contents are don't-care.
- Write side:
  - in_ready = (ram_cnt != DEPTH).
  - Accept when in_valid & in_ready; ram_write_a = accept, combinational, same cycle. wr_ptr increments at the edge and wraps DEPTH-1 -> 0.
  - in_valid with in_ready=0 is ignored. No overwrite, no error flag.
- ram_cnt: +1 on accept, -1 on read issue, unchanged when both occur.
  - Because it is registered, a read only ever targets an address written on an earlier edge. No same-address read-during-write occurs.
- Read issue:
  - ram_en_b = (ram_cnt != 0) & (obuf_cnt + rd_inflight - pop < 2), where pop = out_valid & out_ready.
  - On issue, rd_ptr increments with wrap. rd_inflight <= ram_en_b.
- Output buffer:
  - 2-entry FIFO. When rd_inflight=1, ram_dout_b is pushed at the edge.
  - out_data/out_valid show the buffer head. Push and pop in the same cycle are both honoured, and the buffer never overflows.
- Latency:
  - Word accepted at edge E0 into an empty FIFO: read issued in cycle E0..E1, data on ram_dout_b after E1, out_valid=1 after E2. Latency is 2 cycles.
- Throughput: one word per clock sustained on both sides simultaneously.
- count = ram_cnt + rd_inflight + obuf_cnt, maximum DEPTH+2. Updated at every edge.
- Order is strict FIFO across pointer wrap-around.

Optional Feature:
- Macro: GSM_RAM_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds output port almost_full (1 bit), registered, reset 0.
  - almost_full = 1 when the next-state count >= AF_LEVEL.
  - Updated on the same edge as count.
- Undefined: the port and its logic are absent; AF_LEVEL is unused.

Test Plan:
1. AWIDTH=4, reset, write 0x001..0x003 back-to-back, out_ready=1 -> out_valid rises 2 cycles after the first accept; outputs 0x001,0x002,0x003 on consecutive cycles; count returns to 0.
2. out_ready=0, write 20 words -> first 18 accepted (16 RAM + 2 buffer); in_ready=0 thereafter; count=18; ram_write_a never asserted while in_ready=0.
3. Full FIFO, then out_ready=1 and in_valid=1 continuously for 64 cycles -> one word each way per cycle; sequence continuous across wr_ptr/rd_ptr wrap 15->0; count stays 17 or 18.
4. Random in_valid/out_ready (50%) over 2000 words -> scoreboard order matches; count equals accepted minus popped every cycle.
5. rst_n low for 1 cycle mid-stream with 10 words held -> out_valid=0 and count=0 immediately; next written 0x0AA is the first word out.
6. With GSM_RAM_FIFO_ALMOST_FULL_EN and AF_LEVEL=12 -> almost_full rises on the edge count reaches 12 and falls on the edge count reaches 11.
